// File: rtl/modexp_pkg.sv
// Shared definitions for the modexp scheduler: FSM states and default sizing.
package modexp_pkg;

  localparam int DEF_WIDTH          = 32;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter width able to hold the value 'cycles' itself.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request after
// last_grant, wrapping around; the caller owns the last_grant register.
module rr_arbiter
  import modexp_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDW = $clog2(NUM_REQ);

  int   idx;
  logic found;

  // Scan NUM_REQ positions starting just after the previous winner; the
  // previous winner itself is looked at last so it cannot starve the others.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        found     = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/modexp_sched.sv
// Shares one modexp engine among NUM_REQ requesters: round-robin accept,
// start/done handshake with a watchdog, tagged response with backpressure.
module modexp_sched
  import modexp_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*WIDTH-1:0]   req_m,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       resp_err,
  output logic                       eng_start,
  output logic [WIDTH-1:0]           eng_a,
  output logic [WIDTH-1:0]           eng_b,
  output logic [WIDTH-1:0]           eng_m,
  input  logic                       eng_done,
  input  logic [WIDTH-1:0]           eng_result
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = cnt_width(TIMEOUT_CYCLES);

  state_t             state, state_nxt;
  logic [IDW-1:0]     last_grant;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [WDW-1:0]     wd_cnt;
  logic               arb_en;
  logic               accept;
  logic               done_seen;
  logic               wd_expired;
  logic [WIDTH-1:0]   sel_a, sel_b, sel_m;

  // Gating with reset_n keeps req_ready low while reset is held, even though
  // the state register already sits in IDLE.
  assign arb_en = (state == IDLE) && reset_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign sel_a     = req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b     = req_b[grant_idx*WIDTH +: WIDTH];
  assign sel_m     = req_m[grant_idx*WIDTH +: WIDTH];

  // wd_cnt is zero in the first WAIT cycle, which doubles as the blanking
  // window for a done level left over from the previous operation.
  assign done_seen  = (wd_cnt != '0) && eng_done;
  assign wd_expired = (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    resp_valid = 1'b0;
    eng_start  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (sel_m == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_seen || wd_expired) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, watchdog and response registers. Response fields are
  // written only on the way into RESP, so they hold while backpressured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDW'(NUM_REQ - 1);
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
      eng_m      <= '0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant_idx;
            resp_id    <= grant_idx;
            eng_a      <= sel_a;
            eng_b      <= sel_b;
            eng_m      <= sel_m;
            if (sel_m == '0) begin
              resp_data <= '0;
              resp_err  <= 1'b1;
            end
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          if (done_seen) begin
            resp_data <= eng_result;
            resp_err  <= 1'b0;
          end else if (wd_expired) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_sched.sv
// Self-checking bench for modexp_sched with a behavioural engine model,
// constant vector tables and randomized multi-requester traffic.
module tb_modexp_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;
  localparam int IDW     = $clog2(NUM_REQ);

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a, req_b, req_m;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [IDW-1:0]           resp_id;
  logic [WIDTH-1:0]         resp_data;
  logic                     resp_err;
  logic                     eng_start;
  logic [WIDTH-1:0]         eng_a, eng_b, eng_m;
  logic                     engDone;
  logic [WIDTH-1:0]         engResult;

  modexp_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_m      (req_m),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_m      (eng_m),
    .eng_done   (engDone),
    .eng_result (engResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a, b, m, expData;
    logic        expErr;
  } op_t;

  int  vectors = 0;
  int  miscompares = 0;
  int  cycle = 0;
  int  startCount = 0;
  int  lastStartCycle = -1;
  int  modelLast = NUM_REQ - 1;
  op_t opQ [NUM_REQ][$];
  op_t expQ[$];
  int  acceptLog[$];

  // Engine behaviour knobs
  bit  engHang = 1'b0;
  int  engStaleMode = 0;
  int  engLatFix = 0;
  bit  engBusy, engDrop;
  int  engCnt;
  logic [WIDTH-1:0] engPend;

  function automatic logic [31:0] refModexp(input logic [31:0] a, b, m);
    logic [63:0] r, base, mm;
    logic [31:0] e;
    if (m == 0) return 32'd0;
    mm = {32'd0, m};
    r = 64'd1 % mm;
    base = {32'd0, a} % mm;
    e = b;
    while (e != 0) begin
      if (e[0]) r = (r * base) % mm;
      base = (base * base) % mm;
      e = e >> 1;
    end
    return r[31:0];
  endfunction

  function automatic int expectedGrant(input logic [NUM_REQ-1:0] v);
    int c;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (modelLast + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Engine: done is a level that stays high until the next start; in stale
  // mode it lingers for one extra cycle after start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      engDone <= 1'b0; engBusy <= 1'b0; engDrop <= 1'b0;
      engCnt <= 0; engResult <= '0; engPend <= '0;
    end else if (eng_start) begin
      engBusy <= 1'b1;
      engPend <= refModexp(eng_a, eng_b, eng_m);
      engCnt  <= (engLatFix >= 0) ? engLatFix : int'($urandom_range(0, 5));
      if (engStaleMode == 1 || (engStaleMode == 2 && $urandom_range(0, 1) == 1)) engDrop <= 1'b1;
      else engDone <= 1'b0;
    end else if (engDrop) begin
      engDone <= 1'b0;
      engDrop <= 1'b0;
    end else if (engBusy && !engHang) begin
      if (engCnt == 0) begin
        engDone <= 1'b1; engResult <= engPend; engBusy <= 1'b0;
      end else engCnt <= engCnt - 1;
    end
  end

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (eng_start) begin
      startCount++;
      lastStartCycle = cycle;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setOps(input int i, input logic [31:0] a, b, m);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_m[i*WIDTH +: WIDTH] = m;
  endtask

  task automatic applyStimulus(input int id, input logic [31:0] a, b, m, output int acc, output bit ok);
    ok = 1'b0;
    acc = -1;
    setOps(id, a, b, m);
    req_valid[id] = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        acc = cycle;
        modelLast = id;
      end
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
    if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitResp(input int maxCyc, output logic [IDW-1:0] id, output logic [31:0] data,
                          output logic err, output int rc, output bit ok);
    ok = 1'b0;
    rc = -1; id = '0; data = '0; err = 1'b0;
    resp_ready = 1'b1;
    for (int n = 0; n < maxCyc && !ok; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1; id = resp_id; data = resp_data; err = resp_err; rc = cycle;
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    if (!ok) checkOutput("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic runTxn(input string name, input int id, input logic [31:0] a, b, m,
                        input logic [31:0] expData, input logic expErr, input int expLat, input int expStarts);
    int tAcc, tResp, s0;
    bit ok1, ok2;
    logic [IDW-1:0] rid;
    logic [31:0] rd;
    logic re;
    s0 = startCount;
    applyStimulus(id, a, b, m, tAcc, ok1);
    if (ok1) begin
      waitResp(TIMEOUT + 50, rid, rd, re, tResp, ok2);
      if (ok2) begin
        checkOutput({name, ".id"}, 64'(rid), 64'(id));
        checkOutput({name, ".data"}, 64'(rd), 64'(expData));
        checkOutput({name, ".err"}, 64'(re), 64'(expErr));
        checkOutput({name, ".starts"}, 64'(startCount - s0), 64'(expStarts));
        if (expLat >= 0) checkOutput({name, ".latency"}, 64'(tResp - tAcc), 64'(expLat));
        if (expStarts == 1 && expLat >= 0)
          checkOutput({name, ".start_cycle"}, 64'(lastStartCycle - tAcc), 64'd1);
      end
    end
  endtask

  // Multi-requester traffic: per-requester queues feed valid/ready, a
  // scoreboard checks the round-robin winner and the in-order responses.
  task automatic runTraffic(input int validPct, input int readyPct, input int maxCycles);
    int cyc, g, a;
    bit fin, pending;
    logic [NUM_REQ-1:0] xfer, expOh;
    op_t o;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && opQ[i].size() > 0 && $urandom_range(0, 99) < validPct) begin
          setOps(i, opQ[i][0].a, opQ[i][0].b, opQ[i][0].m);
          req_valid[i] = 1'b1;
        end
      resp_ready = ($urandom_range(0, 99) < readyPct);
      @(negedge clk);
      xfer = req_valid & req_ready;
      if ($countones(req_ready) > 1) checkOutput("ready_onehot", 64'(req_ready), 64'd0);
      if (xfer != '0) begin
        g = expectedGrant(req_valid);
        expOh = '0;
        if (g >= 0) expOh[g] = 1'b1;
        checkOutput("rr_grant", 64'(xfer), 64'(expOh));
        a = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (xfer[i]) a = i;
        o = opQ[a][0];
        o.id = a;
        expQ.push_back(o);
        acceptLog.push_back(a);
        modelLast = a;
      end
      if (resp_valid && resp_ready) begin
        if (expQ.size() == 0) checkOutput("spurious_resp", 64'd1, 64'd0);
        else begin
          o = expQ.pop_front();
          checkOutput("traffic.id", 64'(resp_id), 64'(o.id));
          checkOutput("traffic.data", 64'(resp_data), 64'(o.expData));
          checkOutput("traffic.err", 64'(resp_err), 64'(o.expErr));
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (xfer[i]) begin
          req_valid[i] = 1'b0;
          void'(opQ[i].pop_front());
        end
      cyc++;
      pending = (expQ.size() != 0);
      for (int i = 0; i < NUM_REQ; i++) if (opQ[i].size() != 0) pending = 1'b1;
      if (!pending) fin = 1'b1;
      else if (cyc >= maxCycles) begin
        checkOutput("traffic_budget", 64'(cyc), 64'(maxCycles - 1));
        for (int i = 0; i < NUM_REQ; i++) opQ[i].delete();
        expQ.delete();
        req_valid = '0;
        fin = 1'b1;
      end
    end
    resp_ready = 1'b0;
  endtask

  function automatic op_t mkOp(input logic [31:0] a, b, m, expData, input logic expErr);
    op_t o;
    o.id = 0; o.a = a; o.b = b; o.m = m; o.expData = expData; o.expErr = expErr;
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    op_t vecs[$];
    int  s0, t0;
    bit  ok, seen;
    logic [31:0] ra, rb, rm;
    int  sel;

    reset_n = 1'b0;
    req_valid = '0;
    req_a = '0; req_b = '0; req_m = '0;
    resp_ready = 1'b0;

    // Reset values, with a request already pending
    setOps(1, 32'd4, 32'd4, 32'd4);
    req_valid[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst.resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst.resp_id", 64'(resp_id), 64'd0);
    checkOutput("rst.resp_data", 64'(resp_data), 64'd0);
    checkOutput("rst.resp_err", 64'(resp_err), 64'd0);
    checkOutput("rst.eng_start", 64'(eng_start), 64'd0);
    checkOutput("rst.eng_abm", {eng_a, eng_b | eng_m}, 64'd0);
    req_valid = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic transaction with minimum latency
    engLatFix = 0; engStaleMode = 0;
    runTxn("single", 0, 32'd7, 32'd5, 32'd13, 32'd11, 1'b0, 4, 1);
    // Old done still high during the first WAIT cycle must be ignored
    engStaleMode = 1;
    runTxn("blanking", 1, 32'd3, 32'd19, 32'd103, 32'd94, 1'b0, 5, 1);
    engStaleMode = 0;
    runTxn("m_zero", 2, 32'd5, 32'd6, 32'd0, 32'd0, 1'b1, 1, 0);
    // Watchdog expiry, then a normal request must still work
    engHang = 1'b1;
    runTxn("timeout", 1, 32'd1, 32'd2, 32'd5, 32'd0, 1'b1, TIMEOUT + 2, 1);
    engHang = 1'b0;
    runTxn("after_timeout", 3, 32'd3, 32'd19, 32'd103, 32'd94, 1'b0, -1, 1);

    // Table of single transactions with constant expectations
    engLatFix = -1; engStaleMode = 2;
    vecs.push_back(mkOp(32'd7, 32'd5, 32'd13, 32'd11, 1'b0));
    vecs.push_back(mkOp(32'd1, 32'd2, 32'd5, 32'd1, 1'b0));
    vecs.push_back(mkOp(32'd9081235, 32'd3728103, 32'd98234125, 32'd23831250, 1'b0));
    vecs.push_back(mkOp(32'd123, 32'd456, 32'd1, 32'd0, 1'b0));
    vecs.push_back(mkOp(32'd2, 32'd10, 32'd1000, 32'd24, 1'b0));
    vecs.push_back(mkOp(32'd5, 32'd0, 32'd7, 32'd1, 1'b0));
    vecs.push_back(mkOp(32'd10, 32'd3, 32'd7, 32'd6, 1'b0));
    vecs.push_back(mkOp(32'd2, 32'd31, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0));
    vecs.push_back(mkOp(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 1'b0));
    vecs.push_back(mkOp(32'hDEAD_BEEF, 32'd9, 32'd0, 32'd0, 1'b1));
    for (int v = 0; v < vecs.size(); v++)
      runTxn($sformatf("table%0d", v), v % NUM_REQ, vecs[v].a, vecs[v].b, vecs[v].m,
             vecs[v].expData, vecs[v].expErr, -1, vecs[v].expErr ? 0 : 1);

    // Backpressure: response held for 10 cycles while others request
    engLatFix = 0; engStaleMode = 0;
    s0 = startCount;
    applyStimulus(0, 32'd7, 32'd5, 32'd13, t0, ok);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = resp_valid;
      @(posedge clk); #1;
    end
    checkOutput("bp.resp_seen", 64'(seen), 64'd1);
    for (int i = 1; i < NUM_REQ; i++) begin
      setOps(i, 32'd1, 32'd2, 32'd5);
      req_valid[i] = 1'b1;
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checkOutput("bp.resp_valid", 64'(resp_valid), 64'd1);
      checkOutput("bp.resp_fields", {resp_err, 23'd0, 8'(resp_id), resp_data}, {1'b0, 23'd0, 8'd0, 32'd11});
      checkOutput("bp.req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    checkOutput("bp.starts", 64'(startCount - s0), 64'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.handshake_ready", {63'd0, resp_valid} | {59'd0, req_ready, 1'b0}, 64'd1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checkOutput("bp.after_idle", {62'd0, resp_valid, |req_ready}, 64'd0);
    checkOutput("bp.starts_after", 64'(startCount - s0), 64'd1);
    @(posedge clk); #1;

    // Reset during WAIT
    engHang = 1'b1;
    applyStimulus(1, 32'd5, 32'd3, 32'd11, t0, ok);
    repeat (3) @(posedge clk);
    #1;
    setOps(0, 32'd2, 32'd10, 32'd1000);
    setOps(2, 32'd2, 32'd10, 32'd1000);
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    @(negedge clk);
    checkOutput("rstw.ready_in_wait", 64'(req_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("rstw.req_ready", 64'(req_ready), 64'd0);
    checkOutput("rstw.resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rstw.eng_start", 64'(eng_start), 64'd0);
    checkOutput("rstw.eng_a", 64'(eng_a), 64'd0);
    checkOutput("rstw.eng_m", 64'(eng_m), 64'd0);
    @(posedge clk); #1;
    engHang = 1'b0;
    reset_n = 1'b1;
    modelLast = NUM_REQ - 1;
    @(negedge clk);
    checkOutput("rstw.first_grant", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    modelLast = 0;
    begin
      logic [IDW-1:0] rid; logic [31:0] rd; logic re; int rc; bit ok2;
      waitResp(TIMEOUT + 50, rid, rd, re, rc, ok2);
      if (ok2) checkOutput("rstw.resp", {re, 23'd0, 8'(rid), rd}, {1'b0, 23'd0, 8'd0, 32'd24});
    end

    // Simultaneous requests after reset: granted 0,1,2,3
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    modelLast = NUM_REQ - 1;
    engLatFix = -1; engStaleMode = 2;
    acceptLog.delete();
    opQ[0].push_back(mkOp(32'd1, 32'd2, 32'd5, 32'd1, 1'b0));
    opQ[1].push_back(mkOp(32'd7, 32'd5, 32'd13, 32'd11, 1'b0));
    opQ[2].push_back(mkOp(32'd3, 32'd19, 32'd103, 32'd94, 1'b0));
    opQ[3].push_back(mkOp(32'd9081235, 32'd3728103, 32'd98234125, 32'd23831250, 1'b0));
    runTraffic(100, 100, 200);
    checkOutput("multi.count", 64'(acceptLog.size()), 64'd4);
    for (int i = 0; i < acceptLog.size() && i < 4; i++)
      checkOutput($sformatf("multi.order%0d", i), 64'(acceptLog[i]), 64'(i));

    // Randomized traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      rb = (n % 2 == 0) ? $urandom_range(0, 50) : $urandom;
      sel = $urandom_range(0, 19);
      rm = (sel == 0) ? 32'd0 : (sel == 1) ? 32'd1 : $urandom;
      opQ[$urandom_range(0, NUM_REQ - 1)].push_back(mkOp(ra, rb, rm, refModexp(ra, rb, rm), rm == 0));
    end
    runTraffic(50, 70, 5000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
